cdec8_dbgmon_tx: RTL and testbench

Debug-monitor scanner for the CDEC8 datapath. It drives the datapath's resource-address input and reads back the resource-data output. On a start pulse it sweeps addresses `0x00..NUM_RES-1` and captures every byte into an internal buffer, giving one consistent snapshot. It then streams the snapshot to the host PC as an 8N1 UART frame. It sits between the CDEC8 top level and the DE0 UART TX pin.

---
 rtl/cdec8_dbgmon_tx.sv | 180 ++++++++++++++++++
 tb/tb_cdec8_dbgmon_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cdec8_dbgmon_tx.sv
// cdec8_dbgmon_tx
// Debug-monitor scanner for the CDEC8 datapath. On a start request it sweeps
// the resource addresses 0..NUM_RES-1 and stores every byte in a snapshot
// buffer. It then streams the snapshot as 8N1 UART bytes:
//   0xA5 header, buf[0]..buf[NUM_RES-1], optional checksum.
//
// Optional feature macro: DBGMON_CHKSUM_EN
//   When defined, a checksum byte follows the data. It is chosen so that all
//   transmitted bytes sum to 0x00 mod 256.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   snapshot request, honoured only while not busy
//   resad  out  [7:0] resource address to the datapath debug port
//   resdt  in   [7:0] resource data (combinational function of resad)
//   txd    out  UART serial output, idle high
//   busy   out  high from the cycle after an accepted start to the end of the frame
//   done   out  one-cycle pulse after the last stop bit
module cdec8_dbgmon_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_RES      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int            AW       = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    RES_LAST = 8'(NUM_RES - 1);
  localparam logic [7:0]    NRES8    = 8'(NUM_RES);
  localparam logic [7:0]    HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEND_HDR,
    SEND_DATA,
`ifdef DBGMON_CHKSUM_EN
    SEND_SUM,
`endif
    FIN
  } state_t;

  state_t        state_q;
  logic [7:0]    resad_q;
  logic          txd_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] clk_cnt_q;   // cycles elapsed within the current bit
  logic [3:0]    bit_cnt_q;   // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [7:0]    shift_q;     // remaining data bits of the byte on the wire
  logic [7:0]    idx_q;       // next snapshot entry to load into shift_q
`ifdef DBGMON_CHKSUM_EN
  logic [7:0]    sum_q;       // running 0xA5 + sum(buf) mod 256
`endif

  // Snapshot buffer: written during CAPTURE, read with a registered port.
  // The read address runs one byte ahead of the wire, so rd_data_q is settled
  // long before the current byte's stop bit ends.
  logic [7:0]    snap_mem [NUM_RES];
  logic [7:0]    rd_data_q;
  logic [AW-1:0] wr_addr_d;
  logic [AW-1:0] rd_addr_d;
  logic          bit_end_d;

  assign wr_addr_d = resad_q[AW-1:0];
  assign rd_addr_d = (idx_q < NRES8) ? idx_q[AW-1:0] : '0;
  assign bit_end_d = (clk_cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (state_q == CAPTURE) begin
      snap_mem[wr_addr_d] <= resdt;
    end
    rd_data_q <= snap_mem[rd_addr_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      resad_q   <= 8'h00;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      idx_q     <= 8'h00;
`ifdef DBGMON_CHKSUM_EN
      sum_q     <= HDR_BYTE;
`endif
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q <= 1'b0;
          // A start in the FIN cycle is taken directly, giving back-to-back frames.
          if (start) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
            resad_q <= 8'h00;
`ifdef DBGMON_CHKSUM_EN
            sum_q   <= HDR_BYTE;
`endif
          end else begin
            state_q <= IDLE;
          end
        end

        CAPTURE: begin
`ifdef DBGMON_CHKSUM_EN
          sum_q <= sum_q + resdt;
`endif
          if (resad_q == RES_LAST) begin
            // Header start bit goes out on the very next cycle.
            resad_q   <= 8'h00;
            state_q   <= SEND_HDR;
            txd_q     <= 1'b0;
            shift_q   <= HDR_BYTE;
            bit_cnt_q <= 4'd0;
            clk_cnt_q <= '0;
            idx_q     <= 8'h00;
          end else begin
            resad_q <= resad_q + 8'd1;
          end
        end

        default: begin  // SEND_HDR, SEND_DATA, SEND_SUM
          if (!bit_end_d) begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end else begin
            clk_cnt_q <= '0;
            if (bit_cnt_q != 4'd9) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd8) begin
                txd_q <= 1'b1;
              end else begin
                txd_q   <= shift_q[0];
                shift_q <= {1'b0, shift_q[7:1]};
              end
            end else begin
              // Stop bit finished: next byte starts immediately (no idle gap).
              bit_cnt_q <= 4'd0;
              txd_q     <= 1'b0;
              if (idx_q != NRES8) begin
                shift_q <= rd_data_q;
                idx_q   <= idx_q + 8'd1;
                state_q <= SEND_DATA;
              end
`ifdef DBGMON_CHKSUM_EN
              else if (state_q == SEND_DATA) begin
                shift_q <= ~sum_q + 8'd1;
                state_q <= SEND_SUM;
              end
`endif
              else begin
                txd_q   <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= FIN;
              end
            end
          end
        end
      endcase
    end
  end

  assign resad = resad_q;
  assign txd   = txd_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_cdec8_dbgmon_tx.sv
// Self-checking bench for cdec8_dbgmon_tx (CLKS_PER_BIT=4, NUM_RES=16).
// Stimulus predicts each accepted frame from the frame rules and pushes the
// expected bytes with their start cycles; a negedge monitor decodes the UART
// line and checks control outputs against the predicted frame schedule.
module tb_cdec8_dbgmon_tx;

  localparam int CPB  = 4;
  localparam int NRES = 16;
`ifdef DBGMON_CHKSUM_EN
  localparam int NBYTES = NRES + 2;
`else
  localparam int NBYTES = NRES + 1;
`endif
  localparam int FLEN = NRES + 1 + 10 * NBYTES * CPB;  // accept cycle -> done cycle

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] resad;
  logic [7:0] resdt;
  logic       txd;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  exp_t       exp_q [$];
  int         acc_q [$];
  int         next_free = 0;
  int         last_acc = -100000;
  int         mem_mode = 0;  // 0 keep, 1 randomise, 2 fill 0xFF (applied after capture)
  int         n_frames = 0;

  cdec8_dbgmon_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_RES     (NRES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .resad(resad),
    .resdt(resdt),
    .txd  (txd),
    .busy (busy),
    .done (done)
  );

  assign resdt = mem[resad];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // One clock of stimulus; predicts acceptance and the resulting frame.
  task automatic drive(input logic st, input logic rs);
    int sum;
    @(posedge clock);
    #1;
    start = st;
    reset = rs;
    if (rs) begin
      acc_q.delete();
      exp_q.delete();
      next_free = cyc + 1;
      last_acc  = -100000;
    end else if (st && cyc >= next_free) begin
      acc_q.push_back(cyc);
      last_acc = cyc;
      sum = 'hA5;
      exp_q.push_back('{8'hA5, cyc + NRES + 1});
      for (int i = 0; i < NRES; i++) begin
        exp_q.push_back('{mem[i], cyc + NRES + 1 + 10 * CPB * (i + 1)});
        sum = sum + mem[i];
      end
`ifdef DBGMON_CHKSUM_EN
      exp_q.push_back('{8'((256 - (sum % 256)) % 256), cyc + NRES + 1 + 10 * CPB * (NRES + 1)});
`endif
      next_free = cyc + FLEN;
    end
    // Datapath contents change only after the capture window has closed.
    if (cyc == last_acc + NRES + 1) begin
      if (mem_mode == 1) begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
      end else if (mem_mode == 2) begin
        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
      end
    end
  endtask

  task automatic drain();
    while (cyc < next_free + 5) drive(1'b0, 1'b0);
  endtask

  // Monitor: control outputs vs frame schedule, plus UART decoder.
  logic       dec_on = 1'b0;
  int         t0 = 0;
  logic [7:0] sh = 8'h00;

  always @(negedge clock) begin
    int   f, rel;
    logic e_busy, e_done, in_tx;
    logic [7:0] e_resad;
    exp_t e;
    if (reset) begin
      dec_on = 1'b0;
    end else begin
      while (acc_q.size() > 0 && cyc > acc_q[0] + FLEN) void'(acc_q.pop_front());
      e_busy = 1'b0; e_done = 1'b0; e_resad = 8'h00; in_tx = 1'b0;
      if (acc_q.size() > 0) begin
        f = acc_q[0];
        e_busy = (cyc > f) && (cyc < f + FLEN);
        e_done = (cyc == f + FLEN);
        if (cyc >= f + 1 && cyc <= f + NRES) e_resad = 8'(cyc - f - 1);
        in_tx = (cyc >= f + NRES + 1) && (cyc < f + FLEN);
      end
      chk("ctrl{busy,done,resad}", {22'd0, busy, done, resad}, {22'd0, e_busy, e_done, e_resad});
      if (!in_tx) chk("txd_idle", {31'd0, txd}, 32'd1);
      if (done === 1'b1) begin
        n_frames++;
        $display("frame %0d done at cycle %0d", n_frames, cyc);
      end
      if (!dec_on) begin
        if (txd === 1'b0) begin
          dec_on = 1'b1;
          t0 = cyc;
        end
      end else begin
        rel = cyc - t0;
        if (rel >= CPB + CPB / 2 && rel <= 8 * CPB + CPB / 2 && ((rel - CPB / 2) % CPB) == 0) begin
          sh = {txd, sh[7:1]};
        end else if (rel == 9 * CPB + CPB / 2) begin
          dec_on = 1'b0;
          chk("stop_bit", {31'd0, txd}, 32'd1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_byte: got %0h expected no byte (cycle %0d)", sh, t0);
          end else begin
            e = exp_q.pop_front();
            chk("byte", {24'd0, sh}, {24'd0, e.b});
            chk("byte_start_cycle", t0, e.t);
          end
        end
      end
    end
  end

  initial begin
    int c1;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;

    // Reset held 3 cycles, then 100 idle cycles with txd high.
    repeat (3) drive(1'b0, 1'b1);
    repeat (100) drive(1'b0, 1'b0);

    // Basic frame + snapshot consistency + busy rejection (start at +5, +300).
    mem_mode = 2;
    drive(1'b1, 1'b0);
    for (int k = 1; k < FLEN + 10; k++) drive(k == 5 || k == 300, 1'b0);
    drain();

    // Back-to-back frames with start held high.
    mem_mode = 1;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
    repeat (2 * FLEN + 30) drive(1'b1, 1'b0);
    drain();

    // Reset in the middle of data byte 0x58, then a clean frame.
    mem_mode = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    drive(1'b1, 1'b0);
    c1 = NRES + 1 + 30 * CPB + 5 * CPB;
    for (int k = 1; k < c1; k++) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (5) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drain();

    // Random start pulses, random datapath contents, rare resets.
    mem_mode = 1;
    for (int k = 0; k < 5000; k++)
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 2999) == 0);
    drain();

    chk("leftover_expected_bytes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
